// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Reads a burst of words from a synchronous FIFO and presents them on a
//   valid/ready stream. A 2-entry skid buffer absorbs the FIFO's 1-cycle
//   read latency. Reads are throttled so that the number of words buffered
//   plus the number in flight never exceeds two.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           burst request, sampled only in IDLE
//   burst_len       number of words to fetch, latched on an accepted start
//   busy            high while the burst is in progress (BURST/DRAIN)
//   done            one-cycle completion pulse
//   fifo_rd_en      FIFO read strobe
//   fifo_empty      FIFO empty flag
//   fifo_data_out   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_underflow  FIFO underflow flag
//   m_valid, m_data output stream valid and data
//   m_ready         downstream ready
//   words_sent      words handed off in the current or last burst
//   err_underflow   sticky underflow error, cleared on the next accepted start
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [LEN_WIDTH-1:0]  words_sent,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] skid0;   // oldest entry, drives m_data
  logic [DATA_WIDTH-1:0] skid1;
  logic                  pop;
  logic                  push;
  logic                  start_ok;
  logic [1:0]            slots_after;

  assign m_valid  = (occ != 2'd0);
  assign m_data   = skid0;
  assign pop      = m_valid && m_ready;
  assign push     = inflight;
  assign start_ok = (state == IDLE) && start;

  // Buffer slots still committed after this cycle's pop; pop implies occ>=1,
  // so the subtraction cannot wrap. Max value is 3, which fits in 2 bits.
  assign slots_after = occ + {1'b0, inflight} - {1'b0, pop};

  // Combinational path from m_ready keeps the pipeline at one word per cycle.
  assign fifo_rd_en = (state == BURST) && !fifo_empty && (issued < len) &&
                      (slots_after < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      skid0         <= '0;
      skid1         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_sent    <= '0;
      err_underflow <= 1'b0;
    end else begin
      // Read returns one cycle after the strobe; a read in flight at reset
      // is simply never captured.
      inflight <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + 1'b1;

      // Skid buffer: FIFO-ordered, skid0 only changes on a pop or when the
      // buffer is empty, so m_data is stable while a transfer is stalled.
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= fifo_data_out;
          else             skid1 <= fifo_data_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= fifo_data_out;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_data_out;
          end
        end
        default: ;
      endcase

      if (pop) words_sent <= words_sent + 1'b1;

      // An underflow in the same cycle as a start still gets flagged.
      err_underflow <= (start_ok ? 1'b0 : err_underflow) | fifo_underflow;

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len        <= burst_len;
            issued     <= '0;
            words_sent <= '0;
            if (burst_len != '0) begin
              state <= BURST;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        BURST: begin
          if ((issued == len) || (fifo_rd_en && ((issued + 1'b1) == len)))
            state <= DRAIN;
        end
        DRAIN: begin
          if ((words_sent == len) && (occ == 2'd0)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  occ_bound: assert property (@(posedge clk) disable iff (rst) occ != 2'd3);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: table-driven bursts with randomized
// backpressure and FIFO refill, plus hand-written corner-case sequences.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_underflow;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [LW-1:0] words_sent;
  logic          err_underflow;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .words_sent(words_sent),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: words written by the test, read with 1-cycle latency.
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int next_word = 1;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst-level reference: the k-th word delivered must be FIFO word base+k.
  int base, pops, rds, dones, step_n, first_pop, last_pop, first_done;
  logic prev_stall;
  logic [DW-1:0] prev_data;

  task automatic push_word();
    mem[wr_ptr] = next_word[DW-1:0];
    next_word++;
    wr_ptr++;
  endtask

  task automatic begin_track();
    base = rd_ptr; pops = 0; rds = 0; dones = 0; step_n = 0;
    first_pop = -1; last_pop = -1; first_done = -1; prev_stall = 1'b0;
  endtask

  // One clock cycle: sample/check at negedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    step_n++;
    if (fifo_rd_en) begin
      rds++;
      chk("rd_while_empty", fifo_empty, 0);
    end
    chk("reads_ahead_le2", ((rd_ptr - base - pops) <= 2), 1);
    if (prev_stall) begin
      chk("valid_held", m_valid, 1);
      chk("data_stable", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      chk("data_order", m_data, mem[base + pops]);
      if (first_pop < 0) first_pop = step_n;
      last_pop = step_n;
      pops++;
    end
    if (done) begin
      dones++;
      if (first_done < 0) first_done = step_n;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (c % 3) == 0;     // 1,0,0,1,0,0,...
    endcase
  endfunction

  task automatic run_burst(input int len, input int mode, input bit trickle,
                           input int exp_sent, input string tag);
    int max_cyc;
    max_cyc = len * 8 + 40;
    begin_track();
    start = 1'b1; burst_len = LW'(len); m_ready = pick_ready(mode, 0);
    step();
    start = 1'b0;
    for (int c = 1; c < max_cyc && dones == 0; c++) begin
      if (trickle && (wr_ptr - base) < len && $urandom_range(0, 2) == 0) push_word();
      m_ready = pick_ready(mode, c);
      step();
    end
    chk({tag, "_done_once"}, dones, 1);
    chk({tag, "_words_out"}, pops, exp_sent);
    chk({tag, "_fifo_reads"}, rd_ptr - base, exp_sent);
    chk({tag, "_words_sent"}, words_sent, exp_sent);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_err_clear"}, err_underflow, 0);
  endtask

  typedef struct {
    int preload;
    int len;
    int mode;      // 0 always ready, 1 random, 2 toggle 1,0,0
    bit trickle;   // refill FIFO randomly during the burst
    int exp_sent;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{preload: 5,   len: 5,   mode: 2, trickle: 0, exp_sent: 5};
    vecs[1] = '{preload: 1,   len: 1,   mode: 0, trickle: 0, exp_sent: 1};
    vecs[2] = '{preload: 3,   len: 3,   mode: 1, trickle: 0, exp_sent: 3};
    vecs[3] = '{preload: 0,   len: 12,  mode: 1, trickle: 1, exp_sent: 12};
    vecs[4] = '{preload: 20,  len: 16,  mode: 1, trickle: 0, exp_sent: 16};
    vecs[5] = '{preload: 2,   len: 10,  mode: 0, trickle: 1, exp_sent: 10};
    vecs[6] = '{preload: 251, len: 255, mode: 1, trickle: 1, exp_sent: 255};

    rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; fifo_underflow = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_words_sent", words_sent, 0);
    chk("rst_err", err_underflow, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst: 8 words, full throughput. Start is accepted at the end of
    // step 1; the first word is visible two cycles later (step 4).
    repeat (8) push_word();
    run_burst(8, 0, 0, 8, "basic");
    chk("basic_first_pop", first_pop, 4);
    chk("basic_back_to_back", last_pop - first_pop, 7);
    chk("basic_rd_cycles", rds, 8);
    chk("basic_fifo_empty", fifo_empty, 1);

    foreach (vecs[i]) begin
      repeat (vecs[i].preload) push_word();
      run_burst(vecs[i].len, vecs[i].mode, vecs[i].trickle, vecs[i].exp_sent,
                $sformatf("vec%0d", i));
    end

    // Zero length: no reads, done on the cycle after start.
    begin_track();
    start = 1'b1; burst_len = '0; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("zero_done_step", first_done, 2);
    chk("zero_done_once", dones, 1);
    chk("zero_reads", rds, 0);
    chk("zero_words_sent", words_sent, 0);

    // Empty stall: only 2 of 4 words available.
    chk("stall_fifo_empty_pre", fifo_empty, 1);
    repeat (2) push_word();
    begin_track();
    start = 1'b1; burst_len = 8'd4; m_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("stall_words_out", pops, 2);
    chk("stall_busy", busy, 1);
    chk("stall_rd_en", fifo_rd_en, 0);
    chk("stall_no_done", dones, 0);
    repeat (2) push_word();
    for (int c = 0; c < 30 && dones == 0; c++) step();
    chk("stall_done", dones, 1);
    chk("stall_words_total", pops, 4);
    chk("stall_words_sent", words_sent, 4);

    // Reset mid-burst after 3 words delivered.
    repeat (8) push_word();
    begin_track();
    start = 1'b1; burst_len = 8'd8; m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40 && pops < 3; c++) step();
    chk("midrst_reached_3", pops, 3);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_words_sent", words_sent, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    prev_stall = 1'b0;
    run_burst(2, 0, 0, 2, "after_rst");

    // Underflow flag: sticky until the next accepted start.
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    chk("uf_set", err_underflow, 1);
    repeat (3) step();
    chk("uf_held", err_underflow, 1);
    begin_track();
    start = 1'b1; burst_len = 8'd1; m_ready = 1'b1;
    step();
    start = 1'b0;
    chk("uf_cleared_on_start", err_underflow, 0);
    for (int c = 0; c < 20 && dones == 0; c++) step();
    chk("uf_burst_done", dones, 1);
    chk("uf_burst_word", pops, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
